posit_pair_decoder_pipe: RTL
============================

Name: posit_pair_decoder_pipe

Overview:
- Multi-lane, two-stage pipelined decoder for weight/data posit operand pairs. Placed ahead of the posit MAC array.
- Each lane decodes one weight posit and one data posit into sign, combined scale (regime·2^EXP + exponent), mantissa with hidden bit and class.
- Also emits product sign, product scale sum and product class.
- Elastic valid/ready handshake on both sides so the MAC array can apply backpressure.

Parameters:
- WIDTH, 8, posit word width (≥5).
- EXP, 2, exponent field width es (≥0, EXP ≤ WIDTH-3).
- LANES, 4, number of independent operand-pair lanes.
- Derived MTS = WIDTH-3-EXP, mantissa fraction bits.
- Derived SCW = $clog2((WIDTH-2)·2^EXP + 2^EXP) + 1, signed scale width (6 for defaults).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- vld_i  in  1  input beat valid.
- rdy_o  out  1  decoder can accept a beat.
- win  in  LANES·WIDTH  weight posits, lane n at [n·WIDTH +: WIDTH].
- din  in  LANES·WIDTH  data posits, same packing.
- vld_o  out  1  output beat valid.
- rdy_i  in  1  downstream accepts output beat.
- sign_w, sign_d  out  LANES  operand signs.
- scale_w, scale_d  out  LANES·SCW  signed operand scales.
- mts_w, mts_d  out  LANES·(MTS+1)  mantissa {1'b1, fraction}, fraction left-aligned.
- cls_w, cls_d  out  LANES·2  operand class: 00 zero, 01 normal, 10 NaR.
- prod_sign  out  LANES  sign_w ^ sign_d.
- prod_scale  out  LANES·(SCW+1)  scale_w + scale_d, sign-extended.
- prod_cls  out  LANES·2  10 if either operand is NaR, else 00 if either is zero, else 01.

Behaviour:
- Reset (async, rstn low): vld_o=0 and every data output =0. Both stage-valid flags clear. rdy_o=1 one cycle after release.
- Input beat accepted when vld_i & rdy_o.
- Output beat consumed when vld_o & rdy_i.
- Data outputs hold stable while vld_o & ~rdy_i.
- Stage S1 (registered):
  - Class per operand.
  - sign = msb.
  - Magnitude = two's complement of the whole word when msb=1, else the word itself.
- Stage S2 (registered, drives outputs):
  - Leading-run detect on magnitude bits [WIDTH-2:0]. Run bit r, run length k.
  - Regime = k-1 if r=1, else -k. Range −(WIDTH-2) .. WIDTH-2.
  - Skip the terminating bit.
  - Next EXP bits form the exponent. Truncated exponent bits are zero-filled at the LSB side.
  - Remaining bits form the fraction, left-aligned into MTS bits and zero-filled.
  - scale = regime·2^EXP + exponent.
- Zero and NaR operands: sign, scale and mts forced to 0; the class alone identifies them.
- Latency: 2 cycles from acceptance to vld_o when unstalled. Throughput: 1 beat/cycle.
- Pipeline control: each stage loads when empty or when its successor advances.
- rdy_o = ~s1_vld | ~vld_o | rdy_i. Combinational; no combinational path from vld_i.
- Full stall: S1 and S2 both occupied and rdy_i=0. rdy_o=0, no beat lost or duplicated.
- Simultaneous accept and consume while full: both occur in the same cycle.
- Lanes share a single handshake and are never split across beats.
- Reset mid-operation: in-flight beats are discarded and vld_o drops asynchronously.

Optional Feature:
- Macro: POSIT_DEC_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 16 bits.
  - Increments each cycle vld_o & ~rdy_i, saturating at 0xFFFF.
  - Cleared by reset and by new input clr_cnt (1 bit, synchronous, takes priority over increment).
- When undefined: no port, no counter logic.

Test Plan:
- Defaults, lane0 win=0x40, din=0x50, rdy_i=1 -> 2 cycles later: scale_w=0, mts_w=4'b1000, scale_d=2, mts_d=4'b1000, prod_scale=2, prod_cls=01, prod_sign=0.
- Extremes: win=0x7F, din=0x01 -> scale_w=24, scale_d=−24, prod_scale=0. Then win=0xC0, din=0x44 -> sign_w=1, scale_w=0, mts_d=4'b1100, prod_sign=1.
- Specials: win=0x80, din=0x00 -> cls_w=10, cls_d=00, prod_cls=10, scales and mts 0. Then win=0x00, din=0x40 -> prod_cls=00.
- Backpressure: stream 8 beats with vld_i=1, rdy_i held 0 for cycles 3–7 -> rdy_o=0 once both stages are full. Outputs stable while stalled. All 8 beats delivered in order, no duplicates. With macro defined, stall_cnt=5.
- Back-to-back with random rdy_i over 1000 random beats on 4 lanes -> output matches a reference decoder model beat for beat.
- Assert rstn low while 2 beats are in flight -> vld_o=0 and outputs 0 immediately. After release, the first new beat emerges after 2 cycles.

Source files
------------

// File: rtl/posit_pair_decoder_pipe_if.sv
// Handshake and operand/decoded-field bundle for posit_pair_decoder_pipe.
// slave = decoder side, master = upstream producer / downstream MAC side.
interface posit_pair_decoder_pipe_if #(
   parameter int WIDTH = 8,
   parameter int EXP   = 2,
   parameter int LANES = 4
);
   localparam int MTS = WIDTH - 3 - EXP;
   localparam int SCW = $clog2((WIDTH - 2) * (1 << EXP) + (1 << EXP)) + 1;

   logic                        vld_i;
   logic                        rdy_o;
   logic [LANES*WIDTH-1:0]      win;
   logic [LANES*WIDTH-1:0]      din;
   logic                        vld_o;
   logic                        rdy_i;
   logic [LANES-1:0]            sign_w;
   logic [LANES-1:0]            sign_d;
   logic [LANES*SCW-1:0]        scale_w;
   logic [LANES*SCW-1:0]        scale_d;
   logic [LANES*(MTS+1)-1:0]    mts_w;
   logic [LANES*(MTS+1)-1:0]    mts_d;
   logic [LANES*2-1:0]          cls_w;
   logic [LANES*2-1:0]          cls_d;
   logic [LANES-1:0]            prod_sign;
   logic [LANES*(SCW+1)-1:0]    prod_scale;
   logic [LANES*2-1:0]          prod_cls;

   modport slave (
      input  vld_i, win, din, rdy_i,
      output rdy_o, vld_o, sign_w, sign_d, scale_w, scale_d, mts_w, mts_d,
             cls_w, cls_d, prod_sign, prod_scale, prod_cls
   );

   modport master (
      output vld_i, win, din, rdy_i,
      input  rdy_o, vld_o, sign_w, sign_d, scale_w, scale_d, mts_w, mts_d,
             cls_w, cls_d, prod_sign, prod_scale, prod_cls
   );
endinterface

// File: rtl/posit_pair_decoder_pipe.sv
// Two-stage elastic decoder of weight/data posit pairs ahead of the MAC array.
// Optional stall counter enabled by defining POSIT_DEC_STALL_CNT_EN.
module posit_pair_decoder_pipe #(
   parameter int WIDTH = 8,
   parameter int EXP   = 2,
   parameter int LANES = 4
) (
   input  logic                          clk_i,
   input  logic                          rstn,
   posit_pair_decoder_pipe_if.slave      bus
`ifdef POSIT_DEC_STALL_CNT_EN
   ,
   input  logic                          clr_cnt,
   output logic [15:0]                   stall_cnt
`endif
);
   localparam int MTS = WIDTH - 3 - EXP;
   localparam int MW  = MTS + 1;
   localparam int SCW = $clog2((WIDTH - 2) * (1 << EXP) + (1 << EXP)) + 1;
   localparam int PSW = SCW + 1;

   localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-2:0] ONE = {{(WIDTH-2){1'b0}}, 1'b1};
   localparam logic [1:0] CLS_ZERO = 2'b00;
   localparam logic [1:0] CLS_NORM = 2'b01;
   localparam logic [1:0] CLS_NAR  = 2'b10;

   function automatic logic [1:0] classify(input logic [WIDTH-1:0] p);
      if (p == '0)
         return CLS_ZERO;
      else if (p == NAR)
         return CLS_NAR;
      else
         return CLS_NORM;
   endfunction

   // The magnitude msb is always 0 for normal words, so only the low bits are kept.
   function automatic logic [WIDTH-2:0] magnitude(input logic [WIDTH-1:0] p);
      if (p[WIDTH-1])
         return ~p[WIDTH-2:0] + ONE;
      else
         return p[WIDTH-2:0];
   endfunction

   function automatic int run_len(input logic [WIDTH-2:0] b);
      int   k;
      logic run;
      k   = 0;
      run = 1'b1;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (run && (b[i] == b[WIDTH-2]))
            k++;
         else
            run = 1'b0;
      end
      return k;
   endfunction

   // Bits following the regime run and its terminator, left-aligned, zero-filled.
   function automatic logic [WIDTH-2:0] tail(input logic [WIDTH-2:0] b);
      return b << (run_len(b) + 1);
   endfunction

   function automatic logic [SCW-1:0] dec_scale(input logic [WIDTH-2:0] b);
      int               k;
      int               regime;
      logic [WIDTH-2:0] t;
      k      = run_len(b);
      t      = tail(b);
      regime = b[WIDTH-2] ? (k - 1) : -k;
      return SCW'(regime * (1 << EXP) + int'(t >> (WIDTH - 1 - EXP)));
   endfunction

   function automatic logic [MW-1:0] dec_mts(input logic [WIDTH-2:0] b);
      logic [WIDTH-2:0] t;
      logic [WIDTH-2:0] f;
      t = tail(b);
      f = t << EXP;
      return MW'((1 << MTS) | int'(f >> (WIDTH - 1 - MTS)));
   endfunction

   function automatic logic [1:0] prod_class(input logic [1:0] a, input logic [1:0] b);
      if (a == CLS_NAR || b == CLS_NAR)
         return CLS_NAR;
      else if (a == CLS_ZERO || b == CLS_ZERO)
         return CLS_ZERO;
      else
         return CLS_NORM;
   endfunction

   logic [LANES-1:0][WIDTH-1:0] win_v;
   logic [LANES-1:0][WIDTH-1:0] din_v;
   assign win_v = bus.win;
   assign din_v = bus.din;

   logic rdy;
   logic s2_ld;

   // Stage 1: class, sign, magnitude
   logic                        s1_vld_q;
   logic [LANES-1:0][1:0]       s1_cls_w_q, s1_cls_w_d;
   logic [LANES-1:0][1:0]       s1_cls_d_q, s1_cls_d_d;
   logic [LANES-1:0]            s1_sgn_w_q, s1_sgn_w_d;
   logic [LANES-1:0]            s1_sgn_d_q, s1_sgn_d_d;
   logic [LANES-1:0][WIDTH-2:0] s1_mag_w_q, s1_mag_w_d;
   logic [LANES-1:0][WIDTH-2:0] s1_mag_d_q, s1_mag_d_d;

   // Stage 2: decoded fields and products, drive the outputs directly
   logic                        s2_vld_q;
   logic [LANES-1:0]            sign_w_q, sign_w_d;
   logic [LANES-1:0]            sign_d_q, sign_d_d;
   logic [LANES-1:0][SCW-1:0]   scale_w_q, scale_w_d;
   logic [LANES-1:0][SCW-1:0]   scale_d_q, scale_d_d;
   logic [LANES-1:0][MW-1:0]    mts_w_q, mts_w_d;
   logic [LANES-1:0][MW-1:0]    mts_d_q, mts_d_d;
   logic [LANES-1:0][1:0]       cls_w_q, cls_w_d;
   logic [LANES-1:0][1:0]       cls_d_q, cls_d_d;
   logic [LANES-1:0]            prod_sign_q, prod_sign_d;
   logic [LANES-1:0][PSW-1:0]   prod_scale_q, prod_scale_d;
   logic [LANES-1:0][1:0]       prod_cls_q, prod_cls_d;

   assign rdy   = ~s1_vld_q | ~s2_vld_q | bus.rdy_i;
   assign s2_ld = ~s2_vld_q | bus.rdy_i;

   always_comb begin
      s1_cls_w_d = '0;
      s1_cls_d_d = '0;
      s1_sgn_w_d = '0;
      s1_sgn_d_d = '0;
      s1_mag_w_d = '0;
      s1_mag_d_d = '0;
      for (int n = 0; n < LANES; n++) begin
         s1_cls_w_d[n] = classify(win_v[n]);
         s1_cls_d_d[n] = classify(din_v[n]);
         s1_sgn_w_d[n] = win_v[n][WIDTH-1];
         s1_sgn_d_d[n] = din_v[n][WIDTH-1];
         s1_mag_w_d[n] = magnitude(win_v[n]);
         s1_mag_d_d[n] = magnitude(din_v[n]);
      end
   end

   // Zero and NaR carry only their class; every numeric field is forced to 0.
   always_comb begin
      sign_w_d     = '0;
      sign_d_d     = '0;
      scale_w_d    = '0;
      scale_d_d    = '0;
      mts_w_d      = '0;
      mts_d_d      = '0;
      cls_w_d      = '0;
      cls_d_d      = '0;
      prod_sign_d  = '0;
      prod_scale_d = '0;
      prod_cls_d   = '0;
      for (int n = 0; n < LANES; n++) begin
         cls_w_d[n] = s1_cls_w_q[n];
         cls_d_d[n] = s1_cls_d_q[n];
         if (s1_cls_w_q[n] == CLS_NORM) begin
            sign_w_d[n]  = s1_sgn_w_q[n];
            scale_w_d[n] = dec_scale(s1_mag_w_q[n]);
            mts_w_d[n]   = dec_mts(s1_mag_w_q[n]);
         end
         if (s1_cls_d_q[n] == CLS_NORM) begin
            sign_d_d[n]  = s1_sgn_d_q[n];
            scale_d_d[n] = dec_scale(s1_mag_d_q[n]);
            mts_d_d[n]   = dec_mts(s1_mag_d_q[n]);
         end
         prod_sign_d[n]  = sign_w_d[n] ^ sign_d_d[n];
         prod_scale_d[n] = {scale_w_d[n][SCW-1], scale_w_d[n]}
                         + {scale_d_d[n][SCW-1], scale_d_d[n]};
         prod_cls_d[n]   = prod_class(s1_cls_w_q[n], s1_cls_d_q[n]);
      end
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         s1_vld_q     <= 1'b0;
         s1_cls_w_q   <= '0;
         s1_cls_d_q   <= '0;
         s1_sgn_w_q   <= '0;
         s1_sgn_d_q   <= '0;
         s1_mag_w_q   <= '0;
         s1_mag_d_q   <= '0;
         s2_vld_q     <= 1'b0;
         sign_w_q     <= '0;
         sign_d_q     <= '0;
         scale_w_q    <= '0;
         scale_d_q    <= '0;
         mts_w_q      <= '0;
         mts_d_q      <= '0;
         cls_w_q      <= '0;
         cls_d_q      <= '0;
         prod_sign_q  <= '0;
         prod_scale_q <= '0;
         prod_cls_q   <= '0;
      end else begin
         if (rdy) begin
            s1_vld_q <= bus.vld_i;
            if (bus.vld_i) begin
               s1_cls_w_q <= s1_cls_w_d;
               s1_cls_d_q <= s1_cls_d_d;
               s1_sgn_w_q <= s1_sgn_w_d;
               s1_sgn_d_q <= s1_sgn_d_d;
               s1_mag_w_q <= s1_mag_w_d;
               s1_mag_d_q <= s1_mag_d_d;
            end
         end
         if (s2_ld) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               sign_w_q     <= sign_w_d;
               sign_d_q     <= sign_d_d;
               scale_w_q    <= scale_w_d;
               scale_d_q    <= scale_d_d;
               mts_w_q      <= mts_w_d;
               mts_d_q      <= mts_d_d;
               cls_w_q      <= cls_w_d;
               cls_d_q      <= cls_d_d;
               prod_sign_q  <= prod_sign_d;
               prod_scale_q <= prod_scale_d;
               prod_cls_q   <= prod_cls_d;
            end
         end
      end
   end

   assign bus.rdy_o      = rdy;
   assign bus.vld_o      = s2_vld_q;
   assign bus.sign_w     = sign_w_q;
   assign bus.sign_d     = sign_d_q;
   assign bus.scale_w    = scale_w_q;
   assign bus.scale_d    = scale_d_q;
   assign bus.mts_w      = mts_w_q;
   assign bus.mts_d      = mts_d_q;
   assign bus.cls_w      = cls_w_q;
   assign bus.cls_d      = cls_d_q;
   assign bus.prod_sign  = prod_sign_q;
   assign bus.prod_scale = prod_scale_q;
   assign bus.prod_cls   = prod_cls_q;

`ifdef POSIT_DEC_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn)
         stall_cnt_q <= '0;
      else if (clr_cnt)
         stall_cnt_q <= '0;
      else if (s2_vld_q && !bus.rdy_i && (stall_cnt_q != 16'hFFFF))
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stall_cnt = stall_cnt_q;
`endif
endmodule
